// File: rtl/debounce_bank.sv
// Pushbutton conditioner: per-channel 2-flop synchroniser, stability filter,
// one-cycle press/release pulses and an optional hold-to-repeat tick.
module debounce_bank #(
  parameter int   NUM_CH     = 4,
  parameter int   CNT_W      = 20,
  parameter int   STABLE_CNT = 500000,
  parameter logic RST_VAL    = 1'b0,
  parameter int   REPEAT_EN  = 1,
  parameter int   RPT_W      = 26,
  parameter int   REPEAT_DLY = 25000000,
  parameter int   REPEAT_PER = 5000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] pb_in,
  output logic [NUM_CH-1:0] pb_state,
  output logic [NUM_CH-1:0] pb_rise,
  output logic [NUM_CH-1:0] pb_fall,
  output logic [NUM_CH-1:0] pb_tick
);

  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CNT - 1);
  localparam logic [RPT_W-1:0] DLY_MAX    = RPT_W'(REPEAT_DLY - 1);
  localparam logic [RPT_W-1:0] PER_MAX    = RPT_W'(REPEAT_PER - 1);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic             sync0_reg;
      logic             sync1_reg;
      logic             state_reg;
      logic             rise_reg;
      logic             fall_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic             accept;

      // New level has differed from the accepted one for STABLE_CNT edges.
      assign accept = (sync1_reg != state_reg) && (cnt_reg == STABLE_MAX);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync0_reg <= RST_VAL;
          sync1_reg <= RST_VAL;
          state_reg <= RST_VAL;
          cnt_reg   <= '0;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
        end else begin
          sync0_reg <= pb_in[gi];
          sync1_reg <= sync0_reg;
          rise_reg  <= accept & sync1_reg;
          fall_reg  <= accept & ~sync1_reg;
          if ((sync1_reg == state_reg) || accept) begin
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
          if (accept) begin
            state_reg <= sync1_reg;
          end
        end
      end

      assign pb_state[gi] = state_reg;
      assign pb_rise[gi]  = rise_reg;
      assign pb_fall[gi]  = fall_reg;

      if (REPEAT_EN != 0) begin : g_rpt
        logic [RPT_W-1:0] rcnt_reg;
        logic             periodic_reg;
        logic             tick_reg;
        logic             rpt_hit;

        // periodic_reg selects the PER interval once the initial delay tick
        // has fired; rcnt restarts at every tick so it can never wrap.
        assign rpt_hit = state_reg && !accept &&
                         (periodic_reg ? (rcnt_reg == PER_MAX) : (rcnt_reg == DLY_MAX));

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            rcnt_reg     <= '0;
            periodic_reg <= 1'b0;
            tick_reg     <= 1'b0;
          end else begin
            tick_reg <= (accept & sync1_reg) | rpt_hit;
            if (!state_reg || accept || rpt_hit) begin
              rcnt_reg <= '0;
            end else begin
              rcnt_reg <= rcnt_reg + 1'b1;
            end
            if (!state_reg || accept) begin
              periodic_reg <= 1'b0;
            end else if (rpt_hit) begin
              periodic_reg <= 1'b1;
            end
          end
        end

        assign pb_tick[gi] = tick_reg;
      end else begin : g_norpt
        assign pb_tick[gi] = rise_reg;
      end
    end
  endgenerate

endmodule

// File: doc/debounce_bank.md
Name: debounce_bank

Overview:
- Multi-channel, parametrised pushbutton conditioner for the clock simulator's set/mode/advance buttons.
- Each channel has:
  - a 2-flop synchroniser;
  - a counter-based stability filter, so a level is accepted only after it has held for STABLE_CNT cycles;
  - one-cycle press/release pulses;
  - an optional auto-repeat tick for hold-to-advance time setting.
- Sits between the board pushbuttons and the time-setting FSM. It replaces the plain synchroniser-only debounce.

Parameters:
- NUM_CH, 4: number of independent button channels (>=1).
- CNT_W, 20: width of the stability counter. Must satisfy 2^CNT_W > STABLE_CNT.
- STABLE_CNT, 500000: consecutive cycles a new level must hold before acceptance (>=1). 10 ms at 50 MHz.
- RST_VAL, 0: reset/idle level of the synchronisers and pb_state (applies to all channels).
- REPEAT_EN, 1: 1 enables auto-repeat on pb_tick; 0 makes pb_tick identical to pb_rise.
- RPT_W, 26: width of the repeat counter. Must hold max(REPEAT_DLY, REPEAT_PER).
- REPEAT_DLY, 25000000: cycles from accepted press to the first repeat tick (>=1).
- REPEAT_PER, 5000000: cycles between subsequent repeat ticks (>=1).

Ports:
- clk       input   1       system clock, all logic on its rising edge
- rst_n     input   1       asynchronous, active-low reset
- pb_in     input   NUM_CH  raw asynchronous button levels
- pb_state  output  NUM_CH  debounced level per channel
- pb_rise   output  NUM_CH  one-cycle pulse when pb_state goes 0->1
- pb_fall   output  NUM_CH  one-cycle pulse when pb_state goes 1->0
- pb_tick   output  NUM_CH  pb_rise plus auto-repeat pulses while held

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is asynchronous and active-low (rst_n), with synchronous logic on the rising edge of clk.
  - Assertion of rst_n=0 at any time, including mid-count or mid-repeat, immediately forces:
    - sync flops and pb_state to RST_VAL;
    - stability and repeat counters to 0;
    - pb_rise, pb_fall and pb_tick to 0.
  - No pulses are produced on reset release.
- Per channel, fully independent; no shared counters:
  - Synchroniser: sync0 <= pb_in[i]; sync1 <= sync0.
  - Stability counter (register cnt):
    - If sync1 == pb_state: cnt <= 0.
    - If sync1 != pb_state and cnt < STABLE_CNT-1: cnt <= cnt+1.
    - If sync1 != pb_state and cnt == STABLE_CNT-1: pb_state <= sync1 and cnt <= 0.
    - Any return of sync1 to pb_state before acceptance clears cnt. Glitches shorter than STABLE_CNT cycles are fully rejected.
  - Latency: if edge k first captures a new level into sync0 and the level holds, pb_state updates at edge k+STABLE_CNT+1.
- Pulses:
  - pb_rise/pb_fall are registered. Each is high for exactly the one cycle following the edge at which pb_state changes, aligned with the new pb_state value.
  - pb_rise and pb_fall are never high together on a channel.
- Auto-repeat (REPEAT_EN=1):
  - rcnt is cleared at the accepted-press edge e.
  - rcnt increments each edge while pb_state=1.
  - pb_tick pulses (one cycle, same alignment as pb_rise) for edges e, e+REPEAT_DLY, then every REPEAT_PER edges (e+REPEAT_DLY+n*REPEAT_PER).
  - Release (pb_state 1->0) clears rcnt and stops ticks immediately. No tick accompanies pb_fall.
  - rcnt saturates logic-wise, using wrap-free compare/reset against REPEAT_PER after the first tick. No overflow for any hold duration.
- Simultaneous events:
  - Channels changing on the same cycle each produce their own pulses.
  - If release is accepted on the same edge a repeat tick would occur, release wins and no tick is produced.

Test Plan:
- Params STABLE_CNT=4, REPEAT_DLY=10, REPEAT_PER=3, NUM_CH=4, RST_VAL=0.
- Reset: hold rst_n=0 with pb_in=4'hF -> all outputs 0. Release rst_n -> no pulses. Keep pb_in=4'hF -> pb_state=4'hF exactly STABLE_CNT+1 edges after the first capture edge.
- Glitch rejection: ch0 pulse high for 3 cycles, then low -> pb_state[0] stays 0, no pb_rise/pb_tick. Same pulse held 4 cycles -> pb_state[0]=1 and one pb_rise.
- Bounce: ch1 toggles 1,0,1,1,0,1 then steady 1 -> exactly one pb_rise[1], STABLE_CNT+1 edges after the last capture of the steady 1.
- Auto-repeat: ch2 held high for 25 edges after acceptance edge e -> pb_tick[2] at e, e+10, e+13, e+16, e+19, e+22 (6 ticks). Release -> single pb_fall[2], no further ticks.
- Independence/simultaneity: ch0 pressed and ch3 released in the same cycle -> pb_rise[0] and pb_fall[3] asserted in the same cycle, other channels quiet.
- Reset mid-operation: assert rst_n=0 while ch2 is repeating and ch1 is at cnt=2 -> outputs immediately 0. After release with inputs held, full STABLE_CNT qualification restarts from zero.
